// File: rtl/mac_seq_pkg.sv
// ============================================================================
// Module  : mac_seq_pkg
// Brief   : Shared constants for the MAC dot-product sequencer: FSM state
//           encoding and operand/accumulator widths.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mac_seq_pkg;

  localparam int OPND_W = 8;
  localparam int ACC_W  = 16;

  // Sequencer FSM encoding (3-bit, kept as plain constants for legacy tools)
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] CLEAR   = 3'd1;
  localparam logic [2:0] RUN     = 3'd2;
  localparam logic [2:0] DRAIN   = 3'd3;
  localparam logic [2:0] CAPTURE = 3'd4;
  localparam logic [2:0] OUT     = 3'd5;

endpackage : mac_seq_pkg

`default_nettype wire

// File: rtl/mac_dot_sequencer.sv
// ============================================================================
// Module  : mac_dot_sequencer
// Brief   : Drives the 8x8 signed MAC through one dot product of LEN operand
//           pairs: clears the accumulator, streams pairs from a valid/ready
//           source into start/A/B, then presents the 16-bit result on a
//           valid/ready output.
// Options : MAC_DOT_SEQ_AUTOSTART_EN - when defined, a consumed result loops
//           straight back to CLEAR (continuous mode) instead of IDLE.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_dot_sequencer
  import mac_seq_pkg::*;
#(
  parameter int LEN   = 8,
  parameter int CNT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  output logic              busy,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPND_W-1:0] in_a,
  input  logic [OPND_W-1:0] in_b,
  output logic              mac_clr,
  output logic              mac_start,
  output logic [OPND_W-1:0] mac_a,
  output logic [OPND_W-1:0] mac_b,
  input  logic [ACC_W-1:0]  mac_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data
);

  // Count value of the final pair of a vector
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);

  logic [2:0]        state_q,     state_d;
  logic [CNT_W-1:0]  count_q,     count_d;
  logic              mac_clr_q,   mac_clr_d;
  logic              mac_start_q, mac_start_d;
  logic [OPND_W-1:0] mac_a_q,     mac_a_d;
  logic [OPND_W-1:0] mac_b_q,     mac_b_d;
  logic              out_valid_q, out_valid_d;
  logic [ACC_W-1:0]  out_data_q,  out_data_d;
  logic              hs_w;

  assign in_ready  = (state_q == RUN);
  assign busy      = (state_q != IDLE);
  assign hs_w      = in_valid && in_ready;

  assign mac_clr   = mac_clr_q;
  assign mac_start = mac_start_q;
  assign mac_a     = mac_a_q;
  assign mac_b     = mac_b_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  // Next-state logic: FSM, element counter and registered MAC/output drives
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    mac_clr_d   = 1'b0;          // high only for the cycle spent in CLEAR
    mac_start_d = mac_start_q;
    mac_a_d     = mac_a_q;
    mac_b_d     = mac_b_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    case (state_q)
      IDLE: begin
        if (go) begin
          state_d   = CLEAR;
          mac_clr_d = 1'b1;
        end
      end
      CLEAR: begin
        count_d     = '0;
        mac_start_d = 1'b0;
        state_d     = RUN;
      end
      RUN: begin
        if (hs_w) begin
          mac_a_d     = in_a;
          mac_b_d     = in_b;
          mac_start_d = 1'b1;
          count_d     = count_q + CNT_W'(1);
          if (count_q == LAST_CNT) begin
            state_d = DRAIN;
          end
        end else begin
          // Bubble: the accumulator must hold
          mac_start_d = 1'b0;
        end
      end
      DRAIN: begin
        // The MAC adds the last pair on this edge
        mac_start_d = 1'b0;
        state_d     = CAPTURE;
      end
      CAPTURE: begin
        out_data_d  = mac_result;
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
`ifdef MAC_DOT_SEQ_AUTOSTART_EN
          state_d   = CLEAR;
          mac_clr_d = 1'b1;
`else
          state_d   = IDLE;
`endif
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with asynchronous reset; a reset drops any partial vector
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      mac_clr_q   <= 1'b0;
      mac_start_q <= 1'b0;
      mac_a_q     <= '0;
      mac_b_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      mac_clr_q   <= mac_clr_d;
      mac_start_q <= mac_start_d;
      mac_a_q     <= mac_a_d;
      mac_b_q     <= mac_b_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule : mac_dot_sequencer

`default_nettype wire
